// File: rtl/serial_full_adder.sv
// Bit-serial LSB-first adder: one full-adder stage and a carry flop reused over WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_FULL_ADDER_OVF_EN.
module serial_full_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_FULL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             s_bit;
    logic             c_next;
`ifdef SERIAL_FULL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    assign s_bit  = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    assign c_next = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        sum_d   = sum_q;
        c_d     = c_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_FULL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    c_d     = cin;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                s_sh_d = {s_bit, s_sh_q[WIDTH-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                c_d    = c_next;
                cnt_d  = cnt_q + 1'b1;
                // Last bit: publish straight from the adder so sum never shows partial bits.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    sum_d   = {s_bit, s_sh_q[WIDTH-1:1]};
                    cout_d  = c_next;
`ifdef SERIAL_FULL_ADDER_OVF_EN
                    ovf_d   = c_q ^ c_next;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_FULL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_FULL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_FULL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_full_adder.sv
// Self-checking bench for serial_full_adder: timeline model of A+B+cin checked every cycle
// on a WIDTH=8 and a WIDTH=3 instance, plus hand-computed directed vectors.
module tb_serial_full_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] start_v = '0;
    logic [1:0] cin_v = '0;
    logic [7:0] a0 = '0, b0 = '0;
    logic [2:0] a1 = '0, b1 = '0;
    logic [1:0] busy_v, done_v, cout_v;
    logic [7:0] sum0;
    logic [2:0] sum1;
`ifdef SERIAL_FULL_ADDER_OVF_EN
    logic [1:0] ovf_v;
`endif

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    bit          chk_en   = 1'b0;

    always #5 clk = ~clk;

    serial_full_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a0), .b(b0), .cin(cin_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum0), .cout(cout_v[0])
`ifdef SERIAL_FULL_ADDER_OVF_EN
        , .ovf(ovf_v[0])
`endif
    );

    serial_full_adder #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a1), .b(b1), .cin(cin_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum1), .cout(cout_v[1])
`ifdef SERIAL_FULL_ADDER_OVF_EN
        , .ovf(ovf_v[1])
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int unsigned width_of(input int i);
        return (i == 0) ? 8 : 3;
    endfunction

    // Model: an accepted operation occupies WIDTH edges of work, then one done cycle.
    int unsigned edge_n = 0;
    int unsigned acc_edge [2];
    bit          infl     [2];
    int unsigned exp_sum  [2], exp_cout [2], exp_ovf [2];
    int unsigned res_sum  [2], res_cout [2], res_ovf [2];

    always @(posedge clk) begin
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            int unsigned w, av, bv, cv, tot, m1, cmsb;
            w = width_of(i);
            if (rst) begin
                infl[i] = 1'b0;
                res_sum[i] = 0; res_cout[i] = 0; res_ovf[i] = 0;
            end else if (infl[i]) begin
                if (edge_n - acc_edge[i] == w) begin
                    res_sum[i] = exp_sum[i]; res_cout[i] = exp_cout[i]; res_ovf[i] = exp_ovf[i];
                end else if (edge_n - acc_edge[i] == w + 1) begin
                    infl[i] = 1'b0;
                end
            end else if (start_v[i]) begin
                av = (i == 0) ? 32'(a0) : 32'(a1);
                bv = (i == 0) ? 32'(b0) : 32'(b1);
                cv = 32'(cin_v[i]);
                tot = av + bv + cv;
                m1 = (1 << (w - 1)) - 1;
                cmsb = (((av & m1) + (bv & m1) + cv) >> (w - 1)) & 1;
                infl[i] = 1'b1;
                acc_edge[i] = edge_n;
                exp_sum[i] = tot & ((1 << w) - 1);
                exp_cout[i] = (tot >> w) & 1;
                exp_ovf[i] = cmsb ^ exp_cout[i];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int unsigned w, d;
                logic [31:0] s_act;
                w = width_of(i);
                d = edge_n - acc_edge[i];
                s_act = (i == 0) ? 32'(sum0) : 32'(sum1);
                check($sformatf("dut%0d busy", i), 32'(busy_v[i]), 32'(infl[i] && d < w));
                check($sformatf("dut%0d done", i), 32'(done_v[i]), 32'(infl[i] && d == w));
                check($sformatf("dut%0d sum", i), s_act, res_sum[i]);
                check($sformatf("dut%0d cout", i), 32'(cout_v[i]), res_cout[i]);
                check($sformatf("dut%0d busy&done", i), 32'(busy_v[i] & done_v[i]), 0);
`ifdef SERIAL_FULL_ADDER_OVF_EN
                check($sformatf("dut%0d ovf", i), 32'(ovf_v[i]), res_ovf[i]);
`endif
            end
        end
    end

    // Starts one operation at the current negedge and checks the literal result at done.
    task automatic do_op(input int i, input int unsigned av, input int unsigned bv,
                         input bit cv, input int unsigned exp_full, input bit exp_o);
        int unsigned n, w;
        logic [31:0] full;
        w = width_of(i);
        if (i == 0) begin a0 = 8'(av); b0 = 8'(bv); end
        else        begin a1 = 3'(av); b1 = 3'(bv); end
        cin_v[i] = cv;
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
        n = 1;
        while (!done_v[i] && n < 20) begin
            @(negedge clk);
            n++;
        end
        full = (i == 0) ? {23'd0, cout_v[0], sum0} : {28'd0, cout_v[1], sum1};
        check($sformatf("op%0d latency %0h+%0h", i, av, bv), n, w + 1);
        check($sformatf("op%0d result %0h+%0h+%0d", i, av, bv, cv), full, exp_full);
`ifdef SERIAL_FULL_ADDER_OVF_EN
        check($sformatf("op%0d ovf %0h+%0h", i, av, bv), 32'(ovf_v[i]), 32'(exp_o));
`else
        if (exp_o) n = n;
`endif
        @(negedge clk);
    endtask

    initial begin
        int unsigned dcnt, last_done;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset busy", 32'(busy_v[0]), 0);
        check("reset done", 32'(done_v[0]), 0);
        check("reset sum", 32'(sum0), 0);
        check("reset cout", 32'(cout_v[0]), 0);
        rst = 1'b0;
        @(negedge clk);

        do_op(0, 8'h00, 8'h00, 1'b0, 9'h000, 1'b0);
        do_op(0, 8'hFF, 8'h01, 1'b0, 9'h100, 1'b0);
        do_op(0, 8'h5A, 8'hA5, 1'b1, 9'h100, 1'b0);
        do_op(0, 8'h7F, 8'h01, 1'b0, 9'h080, 1'b1);
        do_op(0, 8'h80, 8'h80, 1'b1, 9'h101, 1'b1);

        // start held high with operands changing every cycle
        start_v[0] = 1'b1;
        dcnt = 0;
        last_done = 0;
        for (int k = 1; k <= 30; k++) begin
            a0 = 8'($urandom); b0 = 8'($urandom); cin_v[0] = 1'($urandom);
            @(negedge clk);
            if (done_v[0]) begin
                if (dcnt > 0) check("done spacing", k - last_done, 10);
                else          check("first done", k, 9);
                last_done = k;
                dcnt++;
            end
        end
        check("done count held start", dcnt, 3);
        start_v[0] = 1'b0;
        repeat (12) @(negedge clk);

        // reset in the 3rd RUN cycle discards the operation
        a0 = 8'h12; b0 = 8'h34; cin_v[0] = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort busy", 32'(busy_v[0]), 0);
        check("abort done", 32'(done_v[0]), 0);
        check("abort sum", 32'(sum0), 0);
        rst = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done_v[0]) dcnt++;
        end
        check("no done after abort", dcnt, 0);
        do_op(0, 8'h12, 8'h34, 1'b0, 9'h046, 1'b0);

        // WIDTH=3 exhaustive
        for (int av = 0; av < 8; av++)
            for (int bv = 0; bv < 8; bv++)
                for (int cv = 0; cv < 2; cv++)
                    do_op(1, av, bv, 1'(cv), av + bv + cv,
                          1'(((av >> 2) == (bv >> 2)) && ((((av + bv + cv) >> 2) & 1) != (av >> 2))));

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_full_adder.md
# serial_full_adder

Bit-serial, LSB-first adder: the additive counterpart of the full subtractor cell, reusing one full-adder stage and one carry flip-flop across WIDTH clock cycles. A WIDTH-bit A+B+cin is computed under a start/busy/done handshake. The block sits beside the subtractor datapath as the inverse operation, so a value and the difference taken from it can be recombined.

## Interface
- WIDTH, 8: operand and result width in bits; must be ≥ 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on the accepting edge.
- b  in  WIDTH  operand B; captured on the accepting edge.
- cin  in  1  carry-in; captured on the accepting edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  registered result, A+B+cin mod 2^WIDTH.
- cout  out  1  registered carry out of the MSB.
- ovf  out  1  signed overflow; present only with SERIAL_FULL_ADDER_OVF_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when start=1. On that edge: a_sh ← a, b_sh ← b, c ← cin, cnt ← 0.
  - RUN: each edge computes s = a_sh[0]^b_sh[0]^c and the next carry c ← maj(a_sh[0], b_sh[0], c).
    - s_sh shifts right with s inserted at the MSB; a_sh and b_sh shift right; cnt increments.
    - RUN → DONE on the edge where cnt == WIDTH-1 (the WIDTH-th bit).
  - On entering DONE: sum ← final s_sh, cout ← final carry (and ovf, if enabled).
  - DONE → IDLE unconditionally on the next edge.
- start is ignored in RUN and DONE. A request must still be present in IDLE to be accepted.
- busy = (state == RUN). done = (state == DONE).
- sum, cout and ovf hold their values from the last completed operation until the next completion or reset. They never show intermediate bits.
- cnt is ceil(log2(WIDTH)) bits wide. The sum is modulo 2^WIDTH, and the carry out of the MSB goes only to cout.

## Timing
- Reset values: state IDLE; busy 0, done 0, sum 0, cout 0, ovf 0; shift registers, carry and cnt all 0.
- Latency: start is accepted at edge E0. Bit-operations run at edges E1..E_WIDTH. done is high for exactly the cycle after E_WIDTH, with sum and cout valid in that same cycle.
- Throughput: with start held high, one operation every WIDTH+2 cycles (IDLE, WIDTH × RUN, DONE).
- Operand changes after E0 have no effect on the running operation.
- rst during RUN or DONE wins over everything. On the next edge: IDLE, all outputs 0, no done pulse, and the partial result is discarded.
- rst and start asserted together: rst wins and the request is dropped.

## Configuration
- SERIAL_FULL_ADDER_OVF_EN defined:
  - Port ovf exists.
  - On entering DONE, ovf ← carry into MSB XOR carry out of MSB. This equals (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]) for cin=0.
  - ovf resets to 0 and holds like sum.
- Not defined:
  - No ovf port and no associated logic.
  - All other behaviour is identical.

## Test plan
- WIDTH=8, a=0x00, b=0x00, cin=0, start pulse → busy for 8 cycles, then done one cycle with sum=0x00, cout=0 (ovf=0).
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, done exactly 8 edges after the accepting edge.
- a=0x5A, b=0xA5, cin=1 → sum=0x00, cout=1. Then a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, ovf=1 (macro defined).
- start held high for 30 cycles with new operands each cycle → done pulses spaced exactly 10 cycles apart. Each result matches the operands present at its accepting edge; operands changed mid-RUN are ignored.
- rst asserted at the 3rd RUN cycle of 0x12+0x34 → next cycle busy=0, done=0, sum=0x00. No done pulse follows; a fresh start then yields 0x46.
- WIDTH=3, all 2^7 combinations of a, b and cin → {cout,sum} == a+b+cin for every case, and done never coincides with busy.
